vu_bar_renderer: RTL and testbench

- Pixel source directly upstream of the VGA timing generator. Drives the generator's 8-bit RGB332 `data` input every pixel clock.
- Takes level samples from the audio path and keeps a peak-hold value with decay.
- Renders a horizontal VU bar: green, yellow and red zones, a white peak marker, black background.
- Tracks the raster with its own counters, which run in lockstep with the VGA generator. Both blocks share clock, reset and timing totals.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vu_peak_hold.sv | 48 ++++
 rtl/vu_bar_renderer.sv | 124 ++++++++++++
 tb/tb_vu_bar_renderer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA pixel format, RGB332 palette and default 640x480 timing.
// Used by the timing generator and by the pixel sources feeding it.
package vga_pkg;

  localparam int PIX_W = 8;

  typedef logic [PIX_W-1:0] rgb332_t;

  localparam rgb332_t BLACK  = 8'h00;
  localparam rgb332_t GREEN  = 8'h1C;
  localparam rgb332_t YELLOW = 8'hFC;
  localparam rgb332_t RED    = 8'hE0;
  localparam rgb332_t WHITE  = 8'hFF;

  localparam int H_ADDR_DEF  = 640;
  localparam int H_TOTAL_DEF = 800;
  localparam int V_ADDR_DEF  = 480;
  localparam int V_TOTAL_DEF = 525;

endpackage

// File: rtl/vu_peak_hold.sv
// Peak-hold register with hold counter and per-frame linear decay.
// All state advances only on frame_tick.
module vu_peak_hold
  import vga_pkg::*;
#(
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic [7:0] lvl,
  input  logic [7:0] floor_lvl,
  output logic [7:0] peak
);

  localparam int HCW = $clog2(HOLD_FRAMES + 1);

  logic [HCW-1:0] hold_cnt;
  logic [8:0]     dec;
  logic [7:0]     decayed;

  assign dec = {1'b0, peak} - 9'(DECAY_STEP);

  // Decay clamps at zero, then never drops below the level on display.
  always_comb begin
    decayed = dec[8] ? 8'h00 : dec[7:0];
    if (decayed < floor_lvl)
      decayed = floor_lvl;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      peak     <= 8'h00;
      hold_cnt <= '0;
    end else if (frame_tick) begin
      if (lvl >= peak) begin
        peak     <= lvl;
        hold_cnt <= HCW'(HOLD_FRAMES);
      end else if (hold_cnt != '0) begin
        hold_cnt <= hold_cnt - HCW'(1);
      end else begin
        peak <= decayed;
      end
    end
  end

endmodule

// File: rtl/vu_bar_renderer.sv
// Horizontal VU bar pixel source running in lockstep with the VGA timing.
// Counters lead the registered pixel output by one clock.
module vu_bar_renderer
  import vga_pkg::*;
#(
  parameter int THADDR      = H_ADDR_DEF,
  parameter int H_TOTAL     = H_TOTAL_DEF,
  parameter int TVADDR      = V_ADDR_DEF,
  parameter int V_TOTAL     = V_TOTAL_DEF,
  parameter int BAR_TOP     = 200,
  parameter int BAR_H       = 80,
  parameter int YEL_COL     = 448,
  parameter int RED_COL     = 576,
  parameter int HOLD_FRAMES = 30,
  parameter int DECAY_STEP  = 4
) (
  input  logic             pixel_clock,
  input  logic             reset,
  input  logic [7:0]       level,
  input  logic             level_valid,
  output logic [PIX_W-1:0] data,
  output logic             frame_start
);

  localparam int HW = $clog2(H_TOTAL);
  localparam int VW = $clog2(V_TOTAL);
  localparam int CW = 8 + $clog2(THADDR);

  localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);

  logic [HW-1:0] h;
  logic [VW-1:0] v;
  logic [7:0]    lvl_in;
  logic [7:0]    cur_lvl;
  logic [7:0]    peak;
  logic [CW-1:0] bar_prod;
  logic [CW-1:0] peak_prod;
  int            h_i;
  int            v_i;
  int            bar_len;
  int            peak_col;
  logic          in_bar;
  logic          mark;
  logic          body;
  logic          is_grn;
  logic          is_yel;
  logic          is_red;
  rgb332_t       pix;

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      h <= '0;
      v <= '0;
    end else if (h == H_LAST) begin
      h <= '0;
      v <= (v == V_LAST) ? '0 : v + VW'(1);
    end else begin
      h <= h + HW'(1);
    end
  end

  // frame_start is high while (0,0) is shown; that cycle commits the new level.
  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      lvl_in  <= 8'h00;
      cur_lvl <= 8'h00;
    end else begin
      if (level_valid)
        lvl_in <= level;
      if (frame_start)
        cur_lvl <= lvl_in;
    end
  end

  vu_peak_hold #(
    .HOLD_FRAMES(HOLD_FRAMES),
    .DECAY_STEP (DECAY_STEP)
  ) u_peak (
    .clk       (pixel_clock),
    .rst_n     (reset),
    .frame_tick(frame_start),
    .lvl       (lvl_in),
    .floor_lvl (lvl_in),
    .peak      (peak)
  );

  assign bar_prod  = CW'(cur_lvl) * CW'(THADDR);
  assign peak_prod = CW'(peak) * CW'(THADDR);
  assign bar_len   = int'(bar_prod >> 8);
  assign peak_col  = int'(peak_prod >> 8);

  assign h_i    = int'(h);
  assign v_i    = int'(v);
  assign in_bar = (h_i < THADDR) && (v_i < TVADDR) &&
                  (v_i >= BAR_TOP) && (v_i < BAR_TOP + BAR_H);
  assign mark   = in_bar && (h_i == peak_col) && (peak != 8'h00);
  assign body   = in_bar && !mark && (h_i < bar_len);
  assign is_grn = body && (h_i < YEL_COL);
  assign is_yel = body && (h_i >= YEL_COL) && (h_i < RED_COL);
  assign is_red = body && (h_i >= RED_COL);

  always_comb begin
    pix = BLACK;
    unique case (1'b1)
      mark:    pix = WHITE;
      is_grn:  pix = GREEN;
      is_yel:  pix = YELLOW;
      is_red:  pix = RED;
      default: pix = BLACK;
    endcase
  end

  always_ff @(posedge pixel_clock or negedge reset) begin
    if (!reset) begin
      data        <= BLACK;
      frame_start <= 1'b0;
    end else begin
      data        <= pix;
      frame_start <= (h == '0) && (v == '0);
    end
  end

endmodule

// File: tb/tb_vu_bar_renderer.sv
// Directed table-driven bench for vu_bar_renderer on a shrunken raster.
// Frame is 12 x 6 = 72 cycles; cycle n shows h = n%12, v = (n/12)%6.
module tb_vu_bar_renderer;

  localparam int HT = 12;
  localparam int VT = 6;
  localparam int FR = HT * VT;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] level = 8'h00;
  logic       level_valid = 1'b0;
  logic [7:0] data;
  logic       frame_start;

  int cyc = -1;
  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int         f;
    int         v;
    int         h;
    logic [7:0] exp_d;
    logic       exp_fs;
    bit         stb;
    logic [7:0] lvl;
  } vec_t;

  vec_t tbl[$];

  vu_bar_renderer #(
    .THADDR     (8),
    .H_TOTAL    (HT),
    .TVADDR     (4),
    .V_TOTAL    (VT),
    .BAR_TOP    (1),
    .BAR_H      (2),
    .YEL_COL    (4),
    .RED_COL    (6),
    .HOLD_FRAMES(2),
    .DECAY_STEP (64)
  ) dut (
    .pixel_clock(clk),
    .reset      (rst_n),
    .level      (level),
    .level_valid(level_valid),
    .data       (data),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!rst_n) cyc <= -1;
    else        cyc <= cyc + 1;
  end

  task automatic chk(input string nm, input logic [7:0] d,
                     input logic fs);
    vectors++;
    if (data !== d || frame_start !== fs) begin
      miscompares++;
      $display("FAIL %s: data=%h frame_start=%b, expected data=%h frame_start=%b",
               nm, data, frame_start, d, fs);
    end
  endtask

  task automatic wait_cyc(input int n);
    int guard = 0;
    while (cyc < n && guard < 5000) begin
      @(posedge clk);
      #1;
      guard++;
    end
    if (cyc != n) begin
      vectors++;
      miscompares++;
      $display("FAIL wait_cyc: at cycle %0d, expected cycle %0d", cyc, n);
    end
  endtask

  task automatic strobe(input logic [7:0] x);
    level       = x;
    level_valid = 1'b1;
    @(posedge clk);
    #1;
    level_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    level_valid = 1'b0;
    level       = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("in_reset", 8'h00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic add(input int f, input int v, input int h,
                     input logic [7:0] d, input logic fs = 1'b0,
                     input bit stb = 1'b0, input logic [7:0] lvl = 8'h00);
    vec_t e;
    e.f = f; e.v = v; e.h = h;
    e.exp_d = d; e.exp_fs = fs;
    e.stb = stb; e.lvl = lvl;
    tbl.push_back(e);
  endtask

  initial begin
    // frame 0: empty bar, 255 strobed
    add(0, 0, 0, 8'h00, 1'b1);
    add(0, 0, 1, 8'h00);
    add(0, 0, 5, 8'h00, 1'b0, 1'b1, 8'd255);
    add(0, 1, 0, 8'h00);
    add(0, 1, 7, 8'h00);
    add(0, 5, 11, 8'h00);
    // frame 1: full scale, 128 strobed mid-line
    add(1, 0, 0, 8'h00, 1'b1);
    add(1, 0, 3, 8'h00);
    add(1, 1, 0, 8'h1C);
    add(1, 1, 2, 8'h1C, 1'b0, 1'b1, 8'd128);
    add(1, 1, 3, 8'h1C);
    add(1, 1, 4, 8'hFC);
    add(1, 1, 5, 8'hFC);
    add(1, 1, 6, 8'hE0);
    add(1, 1, 7, 8'hFF);
    add(1, 1, 8, 8'h00);
    add(1, 1, 11, 8'h00);
    add(1, 2, 0, 8'h1C);
    add(1, 2, 6, 8'hE0);
    add(1, 2, 7, 8'hFF);
    add(1, 3, 7, 8'h00);
    add(1, 4, 2, 8'h00);
    add(1, 5, 7, 8'h00);
    // frame 2: level 128 -> bar_len 4, held peak at 7; 0 strobed
    add(2, 1, 0, 8'h1C);
    add(2, 1, 2, 8'h1C, 1'b0, 1'b1, 8'd0);
    add(2, 1, 3, 8'h1C);
    add(2, 1, 4, 8'h00);
    add(2, 1, 6, 8'h00);
    add(2, 1, 7, 8'hFF);
    // frame 3: last hold frame; then decay 191,127,63,0
    add(3, 1, 0, 8'h00);
    add(3, 1, 7, 8'hFF);
    add(4, 1, 0, 8'h00);
    add(4, 1, 5, 8'hFF);
    add(4, 1, 7, 8'h00);
    add(5, 1, 3, 8'hFF);
    add(5, 1, 5, 8'h00);
    add(6, 1, 1, 8'hFF);
    add(6, 1, 3, 8'h00);
    add(7, 1, 1, 8'h00);
    add(7, 2, 1, 8'h00);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      wait_cyc(tbl[i].f * FR + tbl[i].v * HT + tbl[i].h);
      chk($sformatf("f%0d_v%0d_h%0d", tbl[i].f, tbl[i].v, tbl[i].h),
          tbl[i].exp_d, tbl[i].exp_fs);
      if (tbl[i].stb)
        strobe(tbl[i].lvl);
    end

    // reset asserted in the middle of a green pixel
    do_reset();
    wait_cyc(5);
    strobe(8'd255);
    wait_cyc(FR + HT + 2);
    chk("pre_reset_px", 8'h1C, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 8'h00, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cyc(0);
    chk("restart_c0", 8'h00, 1'b1);
    wait_cyc(1);
    chk("restart_c1", 8'h00, 1'b0);
    wait_cyc(FR);
    chk("restart_f1", 8'h00, 1'b1);
    wait_cyc(FR + HT);
    chk("restart_bar0", 8'h00, 1'b0);
    wait_cyc(FR + HT + 6);
    chk("restart_bar6", 8'h00, 1'b0);

    // strobe one cycle before the frame boundary is taken at once
    do_reset();
    wait_cyc(FR - 1);
    strobe(8'd200);
    wait_cyc(FR + HT);
    chk("early_stb_c0", 8'h1C, 1'b0);
    wait_cyc(FR + HT + 6);
    chk("early_stb_pk", 8'hFF, 1'b0);

    // strobe on the boundary cycle waits a frame
    do_reset();
    wait_cyc(FR);
    chk("same_cyc_fs", 8'h00, 1'b1);
    strobe(8'd200);
    wait_cyc(FR + HT);
    chk("same_cyc_f1c0", 8'h00, 1'b0);
    wait_cyc(FR + HT + 6);
    chk("same_cyc_f1c6", 8'h00, 1'b0);
    wait_cyc(2 * FR + HT);
    chk("same_cyc_f2c0", 8'h1C, 1'b0);
    wait_cyc(2 * FR + HT + 6);
    chk("same_cyc_f2pk", 8'hFF, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
